// File: rtl/synth_core_pipe_if.sv
// Operand/result bundle for synth_core_pipe. master is the environment (drives operands and out_ready);
// slave is the core. The ovf signal exists only when SYNTH_CORE_PIPE_OVF_EN is defined.
interface synth_core_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   in_c;
    logic               sel;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [COUNT_W-1:0] out_count;
`ifdef SYNTH_CORE_PIPE_OVF_EN
    logic               ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_c, sel, out_ready,
        input  in_ready, out_valid, result, out_count
`ifdef SYNTH_CORE_PIPE_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, sel, out_ready,
        output in_ready, out_valid, result, out_count
`ifdef SYNTH_CORE_PIPE_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/synth_core_pipe.sv
// result = b * (sel ? c : a*(c+b)) mod 2^WIDTH over 3 register stages (valid after edge k+2, 1/cycle).
// Global stall: in_ready = !out_valid | out_ready; all stages hold together. Option: SYNTH_CORE_PIPE_OVF_EN.
module synth_core_pipe #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    synth_core_pipe_if.slave bus
);
    localparam int W = WIDTH;

    logic               adv;
    logic               s1_vld_q, s1_sel_q;
    logic [W-1:0]       s1_a_q, s1_b_q, s1_c_q, s1_sum_q;
    logic               s2_vld_q, s2_sel_q;
    logic [W-1:0]       s2_b_q, s2_c_q, s2_p1_q;
    logic               out_vld_q;
    logic [W-1:0]       result_q;
    logic [COUNT_W-1:0] count_q;

    logic [W-1:0]       sum_d, p1_d, result_d;
    logic [COUNT_W-1:0] count_d;

`ifdef SYNTH_CORE_PIPE_OVF_EN
    logic               s1_ovf_q, s2_ovf_q, ovf_q;
    logic               s1_ovf_d, s2_ovf_d, ovf_d;
    logic [W:0]         sum_full;
    logic [2*W-1:0]     p1_full, res_full;
`endif

    // Bubbles are deliberately not collapsed: a held output stalls the whole pipe.
    assign adv = !out_vld_q || bus.out_ready;

    always_comb begin
`ifdef SYNTH_CORE_PIPE_OVF_EN
        sum_full = {1'b0, bus.in_c} + {1'b0, bus.in_b};
        p1_full  = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_sum_q};
        res_full = {{W{1'b0}}, s2_b_q} * {{W{1'b0}}, (s2_sel_q ? s2_c_q : s2_p1_q)};
        sum_d    = sum_full[W-1:0];
        p1_d     = p1_full[W-1:0];
        result_d = res_full[W-1:0];
        // p1 loss only matters when p1 is the multiplicand actually used.
        s1_ovf_d = sum_full[W];
        s2_ovf_d = s1_ovf_q || (!s1_sel_q && (p1_full[2*W-1:W] != '0));
        ovf_d    = s2_ovf_q || (res_full[2*W-1:W] != '0);
`else
        sum_d    = bus.in_c + bus.in_b;
        p1_d     = s1_a_q * s1_sum_q;
        result_d = s2_b_q * (s2_sel_q ? s2_c_q : s2_p1_q);
`endif
        count_d  = count_q + ((out_vld_q && bus.out_ready) ? COUNT_W'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sel_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_c_q    <= '0;
            s1_sum_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_sel_q  <= 1'b0;
            s2_b_q    <= '0;
            s2_c_q    <= '0;
            s2_p1_q   <= '0;
            out_vld_q <= 1'b0;
            result_q  <= '0;
            count_q   <= '0;
`ifdef SYNTH_CORE_PIPE_OVF_EN
            s1_ovf_q  <= 1'b0;
            s2_ovf_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            if (adv) begin
                s1_vld_q  <= bus.in_valid;
                s1_sel_q  <= bus.sel;
                s1_a_q    <= bus.in_a;
                s1_b_q    <= bus.in_b;
                s1_c_q    <= bus.in_c;
                s1_sum_q  <= sum_d;
                s2_vld_q  <= s1_vld_q;
                s2_sel_q  <= s1_sel_q;
                s2_b_q    <= s1_b_q;
                s2_c_q    <= s1_c_q;
                s2_p1_q   <= p1_d;
                out_vld_q <= s2_vld_q;
                result_q  <= result_d;
`ifdef SYNTH_CORE_PIPE_OVF_EN
                s1_ovf_q  <= s1_ovf_d;
                s2_ovf_q  <= s2_ovf_d;
                ovf_q     <= ovf_d;
`endif
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_vld_q;
    assign bus.result    = result_q;
    assign bus.out_count = count_q;
`ifdef SYNTH_CORE_PIPE_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
